// File: rtl/register_scoreboard_if.sv
// Issue/retire hazard interface between the decode/writeback stages and the
// register scoreboard.
interface register_scoreboard_if #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4
);
  logic                i_flush;
  logic                i_issue_valid;
  logic                i_issue_re1;
  logic [SEL_W-1:0]    i_issue_rs1;
  logic                i_issue_re2;
  logic [SEL_W-1:0]    i_issue_rs2;
  logic                i_issue_we;
  logic [SEL_W-1:0]    i_issue_ws;
  logic                i_retire_we;
  logic [SEL_W-1:0]    i_retire_ws;
  logic                o_stall;
  logic                o_issue_fire;
  logic [NUM_REGS-1:0] o_pending;
  logic                o_busy;
  logic                o_underflow;

  modport master (
    output i_flush, i_issue_valid, i_issue_re1, i_issue_rs1, i_issue_re2,
           i_issue_rs2, i_issue_we, i_issue_ws, i_retire_we, i_retire_ws,
    input  o_stall, o_issue_fire, o_pending, o_busy, o_underflow
  );

  modport slave (
    input  i_flush, i_issue_valid, i_issue_re1, i_issue_rs1, i_issue_re2,
           i_issue_rs2, i_issue_we, i_issue_ws, i_retire_we, i_retire_ws,
    output o_stall, o_issue_fire, o_pending, o_busy, o_underflow
  );
endinterface

// File: rtl/register_scoreboard.sv
// Per-register pending-write counters: decode issues writes, writeback retires
// them, and the read-after-write / counter-saturation stall is derived locally.
module register_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4,
  parameter int CNT_W    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  register_scoreboard_if.slave  sb
);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0]    r_cnt [NUM_REGS];
  logic                r_underflow;
  logic                w_stall;
  logic                w_fire;
  logic                w_uf_hit;
  logic [NUM_REGS-1:0] w_pending;

  // Stall looks only at registered counts, so a same-cycle retire never bypasses.
  always_comb begin
    w_stall = sb.i_issue_valid &&
              ((sb.i_issue_re1 && (r_cnt[sb.i_issue_rs1] != '0)) ||
               (sb.i_issue_re2 && (r_cnt[sb.i_issue_rs2] != '0)) ||
               (sb.i_issue_we  && (r_cnt[sb.i_issue_ws]  == MAX)));
    w_fire  = sb.i_issue_valid && !w_stall;
  end

  always_comb begin
    w_pending = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_pending[r] = (r_cnt[r] != '0);
    end
  end

  // A retire to an idle register is an error unless a matching issue consumes it.
  always_comb begin
    w_uf_hit = sb.i_retire_we && (r_cnt[sb.i_retire_ws] == '0) &&
               !(w_fire && sb.i_issue_we && (sb.i_issue_ws == sb.i_retire_ws));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
      r_underflow <= 1'b0;
    end else if (sb.i_flush) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        logic inc, dec;
        inc = w_fire && sb.i_issue_we && (sb.i_issue_ws == SEL_W'(r));
        dec = sb.i_retire_we && (sb.i_retire_ws == SEL_W'(r));
        if (inc && !dec)
          r_cnt[r] <= r_cnt[r] + 1'b1;
        else if (dec && !inc && (r_cnt[r] != '0))
          r_cnt[r] <= r_cnt[r] - 1'b1;
      end
      if (w_uf_hit) r_underflow <= 1'b1;
    end
  end

  assign sb.o_stall      = w_stall;
  assign sb.o_issue_fire = w_fire;
  assign sb.o_pending    = w_pending;
  assign sb.o_busy       = |w_pending;
  assign sb.o_underflow  = r_underflow;
endmodule

// File: tb/tb_register_scoreboard.sv
// Directed table-driven bench for register_scoreboard.
module tb_register_scoreboard;
  logic i_clk = 1'b0;
  logic i_reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 i_clk = ~i_clk;

  register_scoreboard_if #(.NUM_REGS(16), .SEL_W(4)) sb_if ();

  register_scoreboard #(.NUM_REGS(16), .SEL_W(4), .CNT_W(2)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .sb      (sb_if)
  );

  typedef struct {
    logic        flush;
    logic        valid;
    logic        re1;
    logic [3:0]  rs1;
    logic        re2;
    logic [3:0]  rs2;
    logic        we;
    logic [3:0]  ws;
    logic        rwe;
    logic [3:0]  rws;
    logic        e_stall;
    logic        e_fire;
    logic [15:0] e_pend;
    logic        e_uf;
  } vec_t;

  vec_t tbl [31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sb_if.i_flush       = v.flush;
    sb_if.i_issue_valid = v.valid;
    sb_if.i_issue_re1   = v.re1;
    sb_if.i_issue_rs1   = v.rs1;
    sb_if.i_issue_re2   = v.re2;
    sb_if.i_issue_rs2   = v.rs2;
    sb_if.i_issue_we    = v.we;
    sb_if.i_issue_ws    = v.ws;
    sb_if.i_retire_we   = v.rwe;
    sb_if.i_retire_ws   = v.rws;
  endtask

  //                  fl va r1 rs1 r2 rs2 we ws rwe rws  stall fire pend   uf
  function automatic vec_t mk(input logic fl, input logic va, input logic r1, input logic [3:0] s1,
                              input logic r2, input logic [3:0] s2, input logic w, input logic [3:0] ws,
                              input logic rw, input logic [3:0] rs, input logic es, input logic ef,
                              input logic [15:0] ep, input logic eu);
    vec_t v;
    v.flush = fl; v.valid = va; v.re1 = r1; v.rs1 = s1; v.re2 = r2; v.rs2 = s2;
    v.we = w; v.ws = ws; v.rwe = rw; v.rws = rs;
    v.e_stall = es; v.e_fire = ef; v.e_pend = ep; v.e_uf = eu;
    return v;
  endfunction

  initial begin
    vec_t v;
    // Post-reset read, then RAW stall on r5 with no same-cycle bypass
    tbl[0]  = mk(0,1,1,3,0,0,0,0,0,0, 0,1,16'h0000,0);
    tbl[1]  = mk(0,1,0,0,0,0,1,5,0,0, 0,1,16'h0000,0);
    tbl[2]  = mk(0,1,0,0,1,5,0,0,0,0, 1,0,16'h0020,0);
    tbl[3]  = mk(0,1,0,0,1,5,0,0,1,5, 1,0,16'h0020,0);
    tbl[4]  = mk(0,1,0,0,1,5,0,0,0,0, 0,1,16'h0000,0);
    // Saturation on r2
    tbl[5]  = mk(0,1,0,0,0,0,1,2,0,0, 0,1,16'h0000,0);
    tbl[6]  = mk(0,1,0,0,0,0,1,2,0,0, 0,1,16'h0004,0);
    tbl[7]  = mk(0,1,0,0,0,0,1,2,0,0, 0,1,16'h0004,0);
    tbl[8]  = mk(0,1,0,0,0,0,1,2,0,0, 1,0,16'h0004,0);
    tbl[9]  = mk(0,1,0,0,0,0,1,2,1,2, 1,0,16'h0004,0);
    tbl[10] = mk(0,1,0,0,0,0,1,2,0,0, 0,1,16'h0004,0);
    tbl[11] = mk(0,1,0,0,0,0,1,2,0,0, 1,0,16'h0004,0);
    tbl[12] = mk(0,0,0,0,0,0,0,0,1,2, 0,0,16'h0004,0);
    tbl[13] = mk(0,0,0,0,0,0,0,0,1,2, 0,0,16'h0004,0);
    tbl[14] = mk(0,0,0,0,0,0,0,0,1,2, 0,0,16'h0004,0);
    tbl[15] = mk(0,0,0,0,0,0,0,0,0,0, 0,0,16'h0000,0);
    // Simultaneous issue and retire on r7
    tbl[16] = mk(0,1,0,0,0,0,1,7,0,0, 0,1,16'h0000,0);
    tbl[17] = mk(0,1,0,0,0,0,1,7,1,7, 0,1,16'h0080,0);
    tbl[18] = mk(0,0,0,0,0,0,0,0,1,7, 0,0,16'h0080,0);
    tbl[19] = mk(0,0,0,0,0,0,0,0,0,0, 0,0,16'h0000,0);
    // Underflow on r9
    tbl[20] = mk(0,0,0,0,0,0,0,0,1,9, 0,0,16'h0000,0);
    tbl[21] = mk(0,0,0,0,0,0,0,0,0,0, 0,0,16'h0000,1);
    // Flush with an issue firing in the flush cycle
    tbl[22] = mk(0,1,0,0,0,0,1,1,0,0, 0,1,16'h0000,1);
    tbl[23] = mk(0,1,0,0,0,0,1,4,0,0, 0,1,16'h0002,1);
    tbl[24] = mk(0,1,0,0,0,0,1,4,0,0, 0,1,16'h0012,1);
    tbl[25] = mk(1,1,0,0,0,0,1,6,1,1, 0,1,16'h0012,1);
    tbl[26] = mk(0,1,1,4,1,1,0,0,0,0, 0,1,16'h0000,1);
    // Read and write of the same register, then rs1==rs2
    tbl[27] = mk(0,1,1,3,0,0,1,3,0,0, 0,1,16'h0000,1);
    tbl[28] = mk(0,1,1,3,1,3,0,0,0,0, 1,0,16'h0008,1);
    tbl[29] = mk(1,0,0,0,0,0,0,0,0,0, 0,0,16'h0008,1);
    tbl[30] = mk(0,1,1,3,1,3,0,0,0,0, 0,1,16'h0000,1);

    // Reset held for two cycles under random inputs
    i_reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge i_clk);
      v = mk($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), 4'($urandom),
             $urandom_range(0,1), 4'($urandom), $urandom_range(0,1), 4'($urandom),
             $urandom_range(0,1), 4'($urandom), 0,0,16'h0,0);
      drive(v);
    end
    @(negedge i_clk);
    i_reset = 1'b0;

    for (int i = 0; i < 31; i++) begin
      if (i != 0) @(negedge i_clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d stall", i), 32'(sb_if.o_stall),      32'(tbl[i].e_stall));
      chk($sformatf("v%0d fire", i),  32'(sb_if.o_issue_fire), 32'(tbl[i].e_fire));
      chk($sformatf("v%0d pend", i),  32'(sb_if.o_pending),    32'(tbl[i].e_pend));
      chk($sformatf("v%0d busy", i),  32'(sb_if.o_busy),       32'(|tbl[i].e_pend));
      chk($sformatf("v%0d uf", i),    32'(sb_if.o_underflow),  32'(tbl[i].e_uf));
    end

    // Reset overrides a same-cycle issue/retire and clears the sticky underflow
    @(negedge i_clk);
    drive(mk(0,1,0,0,0,0,1,0,1,9, 0,0,16'h0,0));
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    drive(mk(0,1,1,0,0,0,0,0,0,0, 0,0,16'h0,0));
    #1;
    chk("rst uf",    32'(sb_if.o_underflow),  32'd0);
    chk("rst pend",  32'(sb_if.o_pending),    32'd0);
    chk("rst busy",  32'(sb_if.o_busy),       32'd0);
    chk("rst stall", 32'(sb_if.o_stall),      32'd0);
    chk("rst fire",  32'(sb_if.o_issue_fire), 32'd1);

    // Issue without a write, with valid low while a register is pending
    @(negedge i_clk);
    drive(mk(0,1,0,0,0,0,1,15,0,0, 0,0,16'h0,0));
    @(negedge i_clk);
    drive(mk(0,0,1,15,0,0,0,0,0,0, 0,0,16'h0,0));
    #1;
    chk("r15 pend",     32'(sb_if.o_pending),    32'h8000);
    chk("r15 novalid",  32'(sb_if.o_stall),      32'd0);
    sb_if.i_issue_valid = 1'b1;
    #1;
    chk("r15 stall",    32'(sb_if.o_stall),      32'd1);
    chk("r15 nofire",   32'(sb_if.o_issue_fire), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
